// File: rtl/multi_channel_timer_pkg.sv
// rtl/multi_channel_timer_pkg.sv - register map, bit positions and prescaler helper for the multi-channel timer
package multi_channel_timer_pkg;

    // Register offsets within a channel's four-word window
    localparam logic [1:0] OFF_TDR  = 2'd0;
    localparam logic [1:0] OFF_TCR  = 2'd1;
    localparam logic [1:0] OFF_TSR  = 2'd2;
    localparam logic [1:0] OFF_TCNT = 2'd3;

    // TCR bit positions
    localparam int TCR_EN      = 0;
    localparam int TCR_LOAD    = 1;
    localparam int TCR_DOWN    = 2;
    localparam int TCR_CKS_LO  = 3;
    localparam int TCR_CKS_HI  = 4;
    localparam int TCR_ONESHOT = 5;
    localparam int TCR_OVF_IE  = 6;
    localparam int TCR_UDF_IE  = 7;
    localparam int TCR_W       = 8;

    // TSR bit positions
    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;
    localparam int TSR_W   = 2;

    // CKS encodings: divide ratio 2^(CKS+1)
    localparam logic [1:0] CKS_DIV2  = 2'd0;
    localparam logic [1:0] CKS_DIV4  = 2'd1;
    localparam logic [1:0] CKS_DIV8  = 2'd2;
    localparam logic [1:0] CKS_DIV16 = 2'd3;

    // tick[k] fires when the low k+1 prescaler bits are all ones
    function automatic logic [3:0] prescale_ticks(input logic [3:0] pre);
        return {&pre[3:0], &pre[2:0], &pre[1:0], pre[0]};
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: TDR/TCR/TSR/TCNT, reload/wrap, flags and irq term
module timer_channel
    import multi_channel_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       tick,
    input  logic             wr_en,
    input  logic [1:0]       wr_off,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] tdr,
    output logic [TCR_W-1:0] tcr,
    output logic [TSR_W-1:0] tsr,
    output logic [CNT_W-1:0] tcnt,
    output logic             irq
);

    logic [CNT_W-1:0] tdr_q, tdr_d;
    logic [TCR_W-1:0] tcr_q, tcr_d;
    logic [TSR_W-1:0] tsr_q, tsr_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             tick_sel;
    logic             ovf_set;
    logic             udf_set;

    // Next-state: load/count/wrap first, then bus writes, then flag sets so hardware set beats w1c
    always_comb begin
        tdr_d    = tdr_q;
        tcr_d    = tcr_q;
        tsr_d    = tsr_q;
        tcnt_d   = tcnt_q;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        tick_sel = tick[3];
        case (tcr_q[TCR_CKS_HI:TCR_CKS_LO])
            CKS_DIV2:  tick_sel = tick[0];
            CKS_DIV4:  tick_sel = tick[1];
            CKS_DIV8:  tick_sel = tick[2];
            CKS_DIV16: tick_sel = tick[3];
            default:   tick_sel = tick[3];
        endcase

        if (tcr_q[TCR_LOAD]) begin
            tcnt_d = tdr_q;
        end else if (tcr_q[TCR_EN] && tick_sel) begin
            if (!tcr_q[TCR_DOWN]) begin
                if (tcnt_q == '1) begin
                    ovf_set = 1'b1;
                    tcnt_d  = tdr_q;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end else begin
                if (tcnt_q == '0) begin
                    udf_set = 1'b1;
                    tcnt_d  = tdr_q;
                end else begin
                    tcnt_d = tcnt_q - CNT_W'(1);
                end
            end
            if ((ovf_set || udf_set) && tcr_q[TCR_ONESHOT]) begin
                tcr_d[TCR_EN] = 1'b0;
            end
        end

        // A software TCR write lands after the one-shot clear, so software wins
        if (wr_en) begin
            case (wr_off)
                OFF_TDR: tdr_d = wdata;
                OFF_TCR: tcr_d = wdata[TCR_W-1:0];
                OFF_TSR: tsr_d = tsr_q & ~wdata[TSR_W-1:0];
                default: ;
            endcase
        end

        if (ovf_set) tsr_d[TSR_OVF] = 1'b1;
        if (udf_set) tsr_d[TSR_UDF] = 1'b1;
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            tdr_q  <= '0;
            tcr_q  <= '0;
            tsr_q  <= '0;
            tcnt_q <= '0;
        end else begin
            tdr_q  <= tdr_d;
            tcr_q  <= tcr_d;
            tsr_q  <= tsr_d;
            tcnt_q <= tcnt_d;
        end
    end

    // Register views and the masked interrupt term
    always_comb begin
        tdr  = tdr_q;
        tcr  = tcr_q;
        tsr  = tsr_q;
        tcnt = tcnt_q;
        irq  = (tsr_q[TSR_OVF] & tcr_q[TCR_OVF_IE]) | (tsr_q[TSR_UDF] & tcr_q[TCR_UDF_IE]);
    end

endmodule

// File: rtl/multi_channel_timer.sv
// rtl/multi_channel_timer.sv - N-channel bus timer: decode, read mux, error response and shared prescaler
module multi_channel_timer
    import multi_channel_timer_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8
) (
    input  logic              timer_clk,
    input  logic              timer_reset,
    input  logic              timer_sel,
    input  logic              timer_enable,
    input  logic              timer_write,
    input  logic [ADDR_W-1:0] timer_address,
    input  logic [CNT_W-1:0]  timer_wdata,
    output logic [CNT_W-1:0]  timer_rdata,
    output logic              timer_ready,
    output logic              timer_slverr,
    output logic [NUM_CH-1:0] timer_irq_vec,
    output logic              timer_irq
);

    localparam logic [ADDR_W:0] MAP_LIMIT = (ADDR_W+1)'(4 * NUM_CH);

    logic [3:0]        pre_q, pre_d;
    logic [3:0]        tick;
    logic              access;
    logic              mapped;
    logic              err;
    logic              wr_ok;
    logic [1:0]        off;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] irq_vec;

    logic [CNT_W-1:0]  tdr_a  [NUM_CH];
    logic [TCR_W-1:0]  tcr_a  [NUM_CH];
    logic [TSR_W-1:0]  tsr_a  [NUM_CH];
    logic [CNT_W-1:0]  tcnt_a [NUM_CH];

    // Free-running prescaler and the tick strobes derived from it
    always_comb begin
        pre_d = pre_q + 4'd1;
        tick  = prescale_ticks(pre_q);
    end

    // Prescaler register
    always_ff @(posedge timer_clk) begin
        if (timer_reset) pre_q <= '0;
        else             pre_q <= pre_d;
    end

    // Address decode, error detection and write qualification; errored writes touch nothing
    always_comb begin
        access = timer_sel & timer_enable;
        off    = timer_address[1:0];
        mapped = ({1'b0, timer_address} < MAP_LIMIT);
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c] = mapped && (timer_address[ADDR_W-1:2] == (ADDR_W-2)'(c));
        end
        err          = access & (~mapped | (timer_write & (off == OFF_TCNT)));
        wr_ok        = access & timer_write & ~err;
        timer_ready  = access;
        timer_slverr = err;
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            timer_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk    (timer_clk),
                .reset  (timer_reset),
                .tick   (tick),
                .wr_en  (wr_ok & hit[c]),
                .wr_off (off),
                .wdata  (timer_wdata),
                .tdr    (tdr_a[c]),
                .tcr    (tcr_a[c]),
                .tsr    (tsr_a[c]),
                .tcnt   (tcnt_a[c]),
                .irq    (irq_vec[c])
            );
        end
    endgenerate

    // Read mux: driven only during a read access phase, zero otherwise
    always_comb begin
        timer_rdata = '0;
        if (access && !timer_write) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hit[c]) begin
                    case (off)
                        OFF_TDR:  timer_rdata = tdr_a[c];
                        OFF_TCR:  timer_rdata = CNT_W'(tcr_a[c]);
                        OFF_TSR:  timer_rdata = CNT_W'(tsr_a[c]);
                        default:  timer_rdata = tcnt_a[c];
                    endcase
                end
            end
        end
    end

    // Interrupt outputs
    always_comb begin
        timer_irq_vec = irq_vec;
        timer_irq     = |irq_vec;
    end

endmodule
